// File: rtl/ppu_write_queue_if.sv
// Avalon-style slave bus between the CPU bridge and the PPU write queue.
interface ppu_write_queue_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              chipselect;
  logic              write;
  logic              read;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] readdata;
  logic              waitrequest;

  modport master (
    output chipselect, write, read, address, write_data,
    input  readdata, waitrequest
  );

  modport slave (
    input  chipselect, write, read, address, write_data,
    output readdata, waitrequest
  );
endinterface

// File: rtl/ppu_write_queue.sv
// CPU-to-PPU write front-end: queues CPU writes and commits them one per cycle
// only inside the safe window, plus vblank IRQ, overflow flag and queue flush.
module ppu_write_queue #(
  parameter int                ADDR_W      = 12,
  parameter int                DATA_W      = 32,
  parameter int                FIFO_DEPTH  = 16,
  parameter int                COMMIT_MODE = 0,
  parameter logic [ADDR_W-1:0] CTRL_ADDR   = {ADDR_W{1'b1}}
) (
  input  logic                            clk,
  input  logic                            reset,
  ppu_write_queue_if.slave                bus,
  input  logic                            vblank,
  input  logic                            ppu_busy,
  output logic                            mem_we,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [DATA_W-1:0]               mem_data,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            irq
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  // Queue storage: plain array, read only on the registered commit path
  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic             irq_en_reg, irq_pending_reg, overflow_reg;
  logic             vblank_d_reg, rise_reg;

  logic is_ctrl, ctrl_wr, push, push_ok, flush, ack, full, empty, window, pop;

  // Bus decode, queue status and commit window
  always_comb begin
    is_ctrl = (bus.address == CTRL_ADDR);
    ctrl_wr = bus.chipselect & bus.write & is_ctrl;
    push    = bus.chipselect & bus.write & ~is_ctrl;
    flush   = ctrl_wr & bus.write_data[2];
    ack     = ctrl_wr & bus.write_data[1];
    full    = (level_reg == LVL_W'(FIFO_DEPTH));
    empty   = (level_reg == '0);
    // A pop in the same cycle never makes room for the push
    push_ok = push & ~full & ~flush;
    window  = (COMMIT_MODE != 0) ? ~ppu_busy : (vblank & ~ppu_busy);
    // Flushing discards the head too, so nothing new is committed that cycle
    pop     = ~empty & window & ~flush;
  end

  // Queue write port (no reset: contents are qualified by the pointers)
  always_ff @(posedge clk) begin
    if (push_ok)
      fifo_mem[wr_ptr_reg] <= {bus.address, bus.write_data};
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Commit port: strobe for one cycle per pop, address/data hold last commit
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      mem_we <= pop;
      if (pop)
        {mem_addr, mem_data} <= fifo_mem[rd_ptr_reg];
    end
  end

  // Control/status: vblank edge detect is registered twice, so a set lands
  // two cycles after vblank rises; a set beats a coincident ack
  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_en_reg      <= 1'b0;
      irq_pending_reg <= 1'b0;
      overflow_reg    <= 1'b0;
      vblank_d_reg    <= 1'b0;
      rise_reg        <= 1'b0;
    end else begin
      vblank_d_reg <= vblank;
      rise_reg     <= vblank & ~vblank_d_reg;
      if (ctrl_wr)
        irq_en_reg <= bus.write_data[0];
      if (rise_reg)
        irq_pending_reg <= 1'b1;
      else if (ack)
        irq_pending_reg <= 1'b0;
      if (push & full & ~flush)
        overflow_reg <= 1'b1;
      else if (ack)
        overflow_reg <= 1'b0;
    end
  end

  // Combinational status read and handshake outputs
  always_comb begin
    bus.readdata = '0;
    if (bus.chipselect & bus.read & is_ctrl)
      bus.readdata[2:0] = {overflow_reg, irq_pending_reg, irq_en_reg};
    bus.waitrequest = full;
    fifo_level      = level_reg;
    irq             = irq_pending_reg & irq_en_reg;
  end
endmodule

// File: tb/tb_ppu_write_queue.sv
// Directed bench: queue-based reference model checked every cycle against the
// COMMIT_MODE=0 instance, plus literal expectations on both commit modes.
module tb_ppu_write_queue;
  localparam logic [11:0] CTRL = 12'hFFF;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic reset1 = 1'b0;
  logic vblank = 1'b0;
  logic ppu_busy = 1'b0;

  logic        mem_we0, mem_we1;
  logic [11:0] mem_addr0, mem_addr1;
  logic [31:0] mem_data0, mem_data1;
  logic [4:0]  level0, level1;
  logic        irq0, irq1;

  int n_vec = 0;
  int n_bad = 0;

  ppu_write_queue_if #(.ADDR_W(12), .DATA_W(32)) bus0 ();
  ppu_write_queue_if #(.ADDR_W(12), .DATA_W(32)) bus1 ();

  ppu_write_queue #(.ADDR_W(12), .DATA_W(32), .FIFO_DEPTH(16), .COMMIT_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .vblank(vblank), .ppu_busy(ppu_busy),
    .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_data(mem_data0),
    .fifo_level(level0), .irq(irq0)
  );

  ppu_write_queue #(.ADDR_W(12), .DATA_W(32), .FIFO_DEPTH(16), .COMMIT_MODE(1)) dut1 (
    .clk(clk), .reset(reset1), .bus(bus1), .vblank(vblank), .ppu_busy(ppu_busy),
    .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_data(mem_data1),
    .fifo_level(level1), .irq(irq1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (mode 0) ----------------
  typedef struct packed {
    logic [11:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  ent_t        m_e;
  bit          started = 1'b0;
  logic        m_we = 1'b0, m_en = 1'b0, m_pend = 1'b0, m_ovf = 1'b0;
  logic [11:0] m_addr = '0;
  logic [31:0] m_data = '0;
  logic        vb1 = 1'b0, vb2 = 1'b0;
  logic        m_cswr, m_ctrl, m_flush, m_full, m_newirq;

  always @(posedge clk) begin
    started = 1'b1;
    if (!reset) begin
      mq.delete();
      m_we = 0; m_addr = 0; m_data = 0;
      m_en = 0; m_pend = 0; m_ovf = 0; vb1 = 0; vb2 = 0;
    end else begin
      m_cswr   = bus0.chipselect && bus0.write;
      m_ctrl   = (bus0.address == CTRL);
      m_flush  = m_cswr && m_ctrl && bus0.write_data[2];
      m_full   = (mq.size() == 16);
      m_newirq = vb1 && !vb2;
      m_we = 0;
      if (mq.size() > 0 && vblank && !ppu_busy && !m_flush) begin
        m_e = mq.pop_front();
        m_we = 1; m_addr = m_e.a; m_data = m_e.d;
      end
      if (m_flush) mq.delete();
      else if (m_cswr && !m_ctrl) begin
        if (m_full) m_ovf = 1;
        else mq.push_back(ent_t'({bus0.address, bus0.write_data}));
      end
      if (m_cswr && m_ctrl) begin
        m_en = bus0.write_data[0];
        if (bus0.write_data[1]) begin m_pend = 0; m_ovf = 0; end
      end
      if (m_newirq) m_pend = 1;
      vb2 = vb1;
      vb1 = vblank;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      chk("model_mem_we", mem_we0, m_we);
      chk("model_mem_addr", mem_addr0, m_addr);
      chk("model_mem_data", mem_data0, m_data);
      chk("model_level", level0, mq.size());
      chk("model_waitreq", bus0.waitrequest, mq.size() == 16);
      chk("model_irq", irq0, m_pend & m_en);
      if (bus0.chipselect && bus0.read && bus0.address == CTRL)
        chk("model_status", bus0.readdata, {29'd0, m_ovf, m_pend, m_en});
      else
        chk("model_readdata0", bus0.readdata, 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit which, input logic [11:0] a, input logic [31:0] d);
    $display("dut%0d write addr=%03h data=%08h", which, a, d);
    if (which) begin
      bus1.chipselect = 1; bus1.write = 1; bus1.address = a; bus1.write_data = d;
      tick();
      bus1.chipselect = 0; bus1.write = 0;
    end else begin
      bus0.chipselect = 1; bus0.write = 1; bus0.address = a; bus0.write_data = d;
      tick();
      bus0.chipselect = 0; bus0.write = 0;
    end
  endtask

  task automatic status(input string nm, input logic [31:0] exp);
    bus0.chipselect = 1; bus0.read = 1; bus0.address = CTRL;
    @(negedge clk);
    $display("dut0 read status=%08h", bus0.readdata);
    chk(nm, bus0.readdata, exp);
    tick();
    bus0.chipselect = 0; bus0.read = 0;
  endtask

  initial begin
    bus0.chipselect = 0; bus0.write = 0; bus0.read = 0; bus0.address = 0; bus0.write_data = 0;
    bus1.chipselect = 0; bus1.write = 0; bus1.read = 0; bus1.address = 0; bus1.write_data = 0;

    // Reset for two cycles
    tick(); tick();
    chk("rst_mem_we", mem_we0, 0);
    chk("rst_mem_addr", mem_addr0, 0);
    chk("rst_mem_data", mem_data0, 0);
    chk("rst_level", level0, 0);
    chk("rst_waitreq", bus0.waitrequest, 0);
    chk("rst_irq", irq0, 0);
    reset = 1;

    // Mode 0: writes held outside vblank, then drained in order
    for (int i = 0; i < 3; i++) wr(0, 12'h010 + 12'(i), 32'hA + 32'(i));
    chk("t2_level3", level0, 3);
    chk("t2_no_we", mem_we0, 0);
    vblank = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_we", mem_we0, 1);
      chk("t2_addr", mem_addr0, 12'h010 + 12'(i));
      chk("t2_data", mem_data0, 32'hA + 32'(i));
      chk("t2_level", level0, 2 - i);
    end
    tick();
    chk("t2_we_off", mem_we0, 0);
    vblank = 0;

    // Fill, overflow, clear
    for (int i = 0; i < 16; i++) wr(0, 12'h100 + 12'(i), 32'h1000 + 32'(i));
    chk("t3_level16", level0, 16);
    chk("t3_waitreq", bus0.waitrequest, 1);
    wr(0, 12'h1FF, 32'hDEAD);
    chk("t3_level_kept", level0, 16);
    status("t3_status_ovf", 32'h6);
    wr(0, CTRL, 32'h2);
    status("t3_status_clr", 32'h0);

    // Drain with ppu_busy toggling: commits only follow idle cycles
    vblank = 1;
    for (int i = 0; i < 34; i++) begin
      ppu_busy = i[0];
      tick();
      chk("t4_we", mem_we0, (i % 2 == 0) && (i < 32));
      if ((i % 2 == 0) && (i < 32)) chk("t4_addr", mem_addr0, 12'h100 + 12'(i / 2));
    end
    chk("t4_empty", level0, 0);
    ppu_busy = 0;
    vblank = 0;

    // IRQ enable, edge timing, set-beats-ack
    wr(0, CTRL, 32'h3);
    chk("t5_irq_clear", irq0, 0);
    vblank = 1;
    tick();
    chk("t5_irq_1cyc", irq0, 0);
    tick();
    chk("t5_irq_2cyc", irq0, 1);
    vblank = 0;
    tick(); tick();
    vblank = 1;
    tick();
    wr(0, CTRL, 32'h3);
    chk("t5_set_wins", irq0, 1);
    wr(0, CTRL, 32'h3);
    chk("t5_ack", irq0, 0);
    vblank = 0;
    tick(); tick();

    // Flush
    for (int i = 0; i < 8; i++) wr(0, 12'h200 + 12'(i), 32'h2000 + 32'(i));
    chk("t6_level8", level0, 8);
    wr(0, CTRL, 32'h5);
    chk("t6_flushed", level0, 0);
    chk("t6_no_we", mem_we0, 0);
    status("t6_status", 32'h1);
    vblank = 1;
    tick(); tick();
    chk("t6_still_no_we", mem_we0, 0);
    vblank = 0;
    tick(); tick();

    // Reset while draining
    for (int i = 0; i < 4; i++) wr(0, 12'h300 + 12'(i), 32'h3000 + 32'(i));
    vblank = 1;
    tick();
    chk("rd_we", mem_we0, 1);
    chk("rd_addr", mem_addr0, 12'h300);
    reset = 0;
    tick();
    chk("rd_we_off", mem_we0, 0);
    chk("rd_level", level0, 0);
    reset = 1;
    vblank = 0;
    tick();

    // COMMIT_MODE=1: commits whenever the PPU port is idle
    reset1 = 1;
    tick();
    wr(1, 12'h020, 32'h55);
    chk("m1_lat1", mem_we1, 0);
    tick();
    chk("m1_we", mem_we1, 1);
    chk("m1_addr", mem_addr1, 12'h020);
    chk("m1_data", mem_data1, 32'h55);
    wr(1, 12'h021, 32'h66);
    ppu_busy = 1;
    tick();
    chk("m1_busy_block", mem_we1, 0);
    ppu_busy = 0;
    tick();
    chk("m1_we2", mem_we1, 1);
    chk("m1_addr2", mem_addr1, 12'h021);
    chk("m1_level", level1, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
